// File: rtl/adder_pipe_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder/subtractor.
// Holds derived-geometry functions, the configuration legality check and the
// signed saturation limits used when ADDER_PIPE_SAT_EN is defined.
package adder_pipe_pkg;

  // Widest datapath the saturation-limit helpers can describe.
  localparam int MAX_W = 64;

  // Number of carry-select blocks across the whole operand.
  function automatic int calc_nblk(input int width, input int blk);
    return width / blk;
  endfunction

  // Number of carry-select blocks resolved by each pipeline stage.
  function automatic int calc_blk_per_stage(input int nblk, input int pipe);
    return nblk / pipe;
  endfunction

  // Geometry must tile exactly: whole blocks per operand, whole blocks per stage.
  function automatic bit cfg_ok(input int width, input int blk, input int pipe);
    bit ok;
    ok = 1'b1;
    if (width < 2 || width > MAX_W) ok = 1'b0;
    if (blk < 1 || pipe < 1) ok = 1'b0;
    if (ok && (width % blk) != 0) ok = 1'b0;
    if (ok && pipe > (width / blk)) ok = 1'b0;
    if (ok && ((width / blk) % pipe) != 0) ok = 1'b0;
    return ok;
  endfunction

  // Largest positive two's-complement value of the given width (0x7F..F).
  function automatic logic [MAX_W-1:0] smax_val(input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Most negative two's-complement value of the given width (0x80..0).
  function automatic logic [MAX_W-1:0] smin_val(input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cs_block.sv
// One BLK-bit carry-select slice: two ripple sums (carry-in 0 and 1) and a select mux.
// Purely combinational, zero latency.
// No flow control; the enclosing pipeline stage decides when the result is captured.
module cs_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK-1:0] sum0;
  logic [BLK-1:0] sum1;
  logic           cout0;
  logic           cout1;

  // Speculative ripple adders for both possible block carry-ins.
  always_comb begin
    logic r0;
    logic r1;
    r0    = 1'b0;
    r1    = 1'b1;
    sum0  = '0;
    sum1  = '0;
    for (int i = 0; i < BLK; i++) begin
      sum0[i] = a[i] ^ b[i] ^ r0;
      r0      = (a[i] & b[i]) | (r0 & (a[i] ^ b[i]));
      sum1[i] = a[i] ^ b[i] ^ r1;
      r1      = (a[i] & b[i]) | (r1 & (a[i] ^ b[i]));
    end
    cout0 = r0;
    cout1 = r1;
  end

  // The real carry-in only steers the precomputed results.
  assign sum  = cin ? sum1  : sum0;
  assign cout = cin ? cout1 : cout0;

endmodule

// File: rtl/adder_pipe_cs.sv
// Pipelined carry-select add/sub with valid/ready stream ports and signed-overflow flag.
// Latency PIPE cycles, throughput one operation per cycle; optional saturation under ADDER_PIPE_SAT_EN.
// Backpressure: a stage loads when empty or when its successor loads; in_ready is that chain, no skid.
module adder_pipe_cs
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 4,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
`ifdef ADDER_PIPE_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int NBLK = calc_nblk(WIDTH, BLK);
  localparam int BPS  = calc_blk_per_stage(NBLK, PIPE);
  localparam int SW   = BPS * BLK;   // result bits resolved per stage

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax_val(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin_val(WIDTH));
`endif

  if (!cfg_ok(WIDTH, BLK, PIPE)) begin : g_bad_cfg
    $error("adder_pipe_cs: WIDTH must tile into BLK blocks and the blocks into PIPE stages");
  end

  logic [PIPE-1:0] vld_q;
  logic [PIPE-1:0] vld_d;
  logic [PIPE-1:0] vld_in;   // valid arriving at each stage's input
  logic [PIPE-1:0] ld;       // stage load enable
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is A + ~B + 1; a borrow-in removes that +1.
  assign b_eff = in_sub ? ~in_b : in_b;
  assign c0    = in_ci ^ in_sub;

  // Load chain runs back from the output so a full pipe can shift while popping.
  always_comb begin
    ld     = '0;
    vld_in = '0;
    vld_d  = '0;
    vld_in[0] = in_valid;
    for (int s = 1; s < PIPE; s++) begin
      vld_in[s] = vld_q[s-1];
    end
    ld[PIPE-1] = ~vld_q[PIPE-1] | out_ready;
    for (int s = PIPE - 2; s >= 0; s--) begin
      ld[s] = ~vld_q[s] | ld[s+1];
    end
    for (int s = 0; s < PIPE; s++) begin
      vld_d[s] = ld[s] ? vld_in[s] : vld_q[s];
    end
  end

  // Stage occupancy; reset drops every in-flight operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[PIPE-1];

  for (genvar s = 0; s < PIPE; s++) begin : g_stage
    localparam int LO = s * SW;      // lowest result bit this stage resolves
    localparam int RW = WIDTH - LO;  // operand bits still unconsumed at this stage

    logic [RW-1:0]    a_i;
    logic [RW-1:0]    b_i;
    logic             c_i;
    logic [SW-1:0]    sl_sum;
    logic             sl_co;
    logic [LO+SW-1:0] acc;           // all result bits resolved so far
    logic             cap;
`ifdef ADDER_PIPE_SAT_EN
    logic             sat_i;
`endif

    // Data registers only move when a real operation enters; bubbles leave them alone.
    assign cap = ld[s] & vld_in[s];

    if (s == 0) begin : g_first
      assign a_i = in_a;
      assign b_i = b_eff;
      assign c_i = c0;
      assign acc = sl_sum;
`ifdef ADDER_PIPE_SAT_EN
      assign sat_i = in_sat;
`endif
    end else begin : g_next
      assign a_i = g_stage[s-1].g_mid.a_q;
      assign b_i = g_stage[s-1].g_mid.b_q;
      assign c_i = g_stage[s-1].g_mid.cy_q;
      assign acc = {sl_sum, g_stage[s-1].g_mid.sum_q};
`ifdef ADDER_PIPE_SAT_EN
      assign sat_i = g_stage[s-1].g_mid.sat_q;
`endif
    end

    // Carry ripples block to block inside the stage; each block already has both sums.
    for (genvar j = 0; j < BPS; j++) begin : g_blk
      logic ci_b;
      logic co_b;
      if (j == 0) begin : g_cin
        assign ci_b = c_i;
      end else begin : g_cin
        assign ci_b = g_blk[j-1].co_b;
      end
      cs_block #(.BLK(BLK)) u_cs (
        .a    (a_i[j*BLK +: BLK]),
        .b    (b_i[j*BLK +: BLK]),
        .cin  (ci_b),
        .sum  (sl_sum[j*BLK +: BLK]),
        .cout (co_b)
      );
    end
    assign sl_co = g_blk[BPS-1].co_b;

    if (s < PIPE - 1) begin : g_mid
      logic [RW-SW-1:0] a_q;
      logic [RW-SW-1:0] b_q;
      logic [LO+SW-1:0] sum_q;
      logic             cy_q;
`ifdef ADDER_PIPE_SAT_EN
      logic             sat_q;
`endif
      // Hand the partial sum, running carry and unconsumed operand bits to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
          cy_q  <= 1'b0;
`ifdef ADDER_PIPE_SAT_EN
          sat_q <= 1'b0;
`endif
        end else if (cap) begin
          a_q   <= a_i[RW-1:SW];
          b_q   <= b_i[RW-1:SW];
          sum_q <= acc;
          cy_q  <= sl_co;
`ifdef ADDER_PIPE_SAT_EN
          sat_q <= sat_i;
`endif
        end
      end
    end else begin : g_last
      logic             cmsb;
      logic             ovf_d;
      logic [WIDTH-1:0] sum_d;
      logic [WIDTH-1:0] sum_q;
      logic             co_q;
      logic             ovf_q;

      // Carry into the MSB is recovered from the MSB sum bit instead of being routed out of the slice.
      assign cmsb  = a_i[RW-1] ^ b_i[RW-1] ^ sl_sum[SW-1];
      assign ovf_d = cmsb ^ sl_co;
`ifdef ADDER_PIPE_SAT_EN
      // A wrapped result with MSB 1 came from positive overflow, so clamp to the positive limit.
      assign sum_d = (sat_i && ovf_d) ? (acc[WIDTH-1] ? SMAX : SMIN) : acc;
`else
      assign sum_d = acc;
`endif

      // Output register; holds while the consumer stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q <= '0;
          co_q  <= 1'b0;
          ovf_q <= 1'b0;
        end else if (cap) begin
          sum_q <= sum_d;
          co_q  <= sl_co;
          ovf_q <= ovf_d;
        end
      end

      assign out_sum = sum_q;
      assign out_co  = co_q;
      assign out_ovf = ovf_q;
    end
  end

endmodule

// File: tb/tb_adder_pipe_cs.sv
// Directed-vector bench for adder_pipe_cs (WIDTH=32, BLK=4, PIPE=2).
// Covers reset, table-driven arithmetic, backpressure, mid-flight reset and a scoreboarded stream.
module tb_adder_pipe_cs;

  localparam int W = 32;
  localparam int B = 4;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ci;
  logic         in_sub;
  logic         in_sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_co;
  logic         out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_pipe_cs #(.WIDTH(W), .BLK(B), .PIPE(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .in_sub    (in_sub),
`ifdef ADDER_PIPE_SAT_EN
    .in_sat    (in_sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .out_ovf   (out_ovf)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic         sat;
    res_t         exp;
  } vec_t;

  function automatic vec_t mkv(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                               input logic sub, input logic sat, input logic [W-1:0] s,
                               input logic co, input logic ovf);
    vec_t v;
    v.a = a; v.b = b; v.ci = ci; v.sub = sub; v.sat = sat;
    v.exp.sum = s; v.exp.co = co; v.exp.ovf = ovf;
    return v;
  endfunction

  // Reference: wide addition, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                 input logic sub, input logic sat);
    logic [W:0]   full;
    logic [W-1:0] be;
    res_t         r;
    be    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci ^ sub};
    r.sum = full[W-1:0];
    r.co  = full[W];
    r.ovf = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
`ifdef ADDER_PIPE_SAT_EN
    if (sat && r.ovf) r.sum = r.sum[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`else
    if (sat) r.ovf = r.ovf;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    in_valid = vld;
    in_a     = v.a;
    in_b     = v.b;
    in_ci    = v.ci;
    in_sub   = v.sub;
    in_sat   = v.sat;
  endtask

  // Single operation through an idle pipe: checks acceptance, latency and result.
  task automatic run_one(input vec_t v, input string tag);
    int k;
    @(negedge clk);
    out_ready = 1'b1;
    drive(v, 1'b1);
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 4 * P) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, P);
    chk({tag, "_sum"}, out_sum, v.exp.sum);
    chk({tag, "_co"},  out_co,  v.exp.co);
    chk({tag, "_ovf"}, out_ovf, v.exp.ovf);
  endtask

  vec_t vt[17];
  vec_t bp[4];
  res_t q[$];

  initial begin
    int idx;
    int got;
    int sent;
    int first_c;
    int last_c;
    int stalls;
    int cyc;
    vec_t rv;
    res_t r;

    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_ci = 1'b0; in_sub = 1'b0; in_sat = 1'b0;

    vt[0]  = mkv(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0000_0000, 1, 0);
    vt[1]  = mkv(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h8000_0000, 0, 1);
    vt[2]  = mkv(32'h0000_0005, 32'h0000_0007, 0, 1, 0, 32'hFFFF_FFFE, 0, 0);
    vt[3]  = mkv(32'h0000_0005, 32'h0000_0007, 1, 1, 0, 32'hFFFF_FFFD, 0, 0);
    vt[4]  = mkv(32'h0000_0000, 32'h0000_0000, 1, 0, 0, 32'h0000_0001, 0, 0);
    vt[5]  = mkv(32'h8000_0000, 32'h0000_0001, 0, 1, 0, 32'h7FFF_FFFF, 1, 1);
    vt[6]  = mkv(32'h0000_0007, 32'h0000_0005, 0, 1, 0, 32'h0000_0002, 1, 0);
    vt[7]  = mkv(32'h1234_5678, 32'h8765_4321, 0, 0, 0, 32'h9999_9999, 0, 0);
    vt[8]  = mkv(32'h8000_0000, 32'h8000_0000, 0, 0, 0, 32'h0000_0000, 1, 1);
    vt[9]  = mkv(32'h0000_FFFF, 32'h0000_0001, 1, 0, 0, 32'h0001_0001, 0, 0);
    vt[10] = mkv(32'h0000_0000, 32'h0000_0000, 0, 1, 0, 32'h0000_0000, 1, 0);
    vt[11] = mkv(32'h0000_0000, 32'h0000_0001, 0, 1, 0, 32'hFFFF_FFFF, 0, 0);
`ifdef ADDER_PIPE_SAT_EN
    vt[12] = mkv(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h7FFF_FFFF, 0, 1);
    vt[13] = mkv(32'h8000_0000, 32'h8000_0000, 0, 0, 1, 32'h8000_0000, 1, 1);
`else
    vt[12] = mkv(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h8000_0000, 0, 1);
    vt[13] = mkv(32'h8000_0000, 32'h8000_0000, 0, 0, 1, 32'h0000_0000, 1, 1);
`endif
    vt[14] = mkv(32'h0000_0001, 32'h0000_0002, 0, 0, 1, 32'h0000_0003, 0, 0);
    vt[15] = mkv(32'h0001_0000, 32'h0000_0001, 0, 1, 0, 32'h0000_FFFF, 1, 0);
    vt[16] = mkv(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 32'h8000_0000, 0, 1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid_low", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_co", out_co, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    // Table-driven arithmetic
    for (int i = 0; i < 17; i++) run_one(vt[i], $sformatf("vec%0d", i));

    // Backpressure: stalled consumer, four-op stream
    for (int i = 0; i < 4; i++) begin
      bp[i].a = 32'h1111_1111 * (i + 1);
      bp[i].b = 32'h0F0F_0F0F + i;
      bp[i].ci = i[0];
      bp[i].sub = i[1];
      bp[i].sat = 1'b0;
      bp[i].exp = model(bp[i].a, bp[i].b, bp[i].ci, bp[i].sub, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) drive(bp[idx], 1'b1); else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    chk("bp_accepted", idx, P);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_hold_sum%0d", c), out_sum, bp[0].exp.sum);
      chk($sformatf("bp_hold_flags%0d", c), {out_co, out_ovf}, {bp[0].exp.co, bp[0].exp.ovf});
      @(negedge clk);
    end
    out_ready = 1'b1;
    got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (idx < 4) drive(bp[idx], 1'b1); else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        chk($sformatf("bp_res%0d", got), {out_sum, out_co, out_ovf}, bp[got].exp);
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    chk("bp_drained", got, 4);
    chk("bp_rate", last_c - first_c, 3);
    @(negedge clk);
    in_valid = 1'b0;

    // Reset with operations in flight
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4 && idx < 2; c++) begin
      @(negedge clk);
      drive(bp[c % 4], 1'b1);
      #1;
      if (in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("mrst_full", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid_async", out_valid, 0);
    chk("mrst_out_sum_clear", out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mrst_no_stale%0d", c), out_valid, 0);
    end
    run_one(vt[7], "mrst_next");

    // Scoreboarded stream with random valid/ready gaps
    q.delete();
    sent = 0; got = 0;
    for (cyc = 0; cyc < 4000 && got < 300; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      rv.a = $urandom; rv.b = $urandom;
      rv.ci = $urandom_range(0, 1); rv.sub = $urandom_range(0, 1); rv.sat = $urandom_range(0, 1);
      drive(rv, (sent < 300) && ($urandom_range(0, 4) != 0));
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_unexpected_output", 1, 0);
        else begin
          r = q.pop_front();
          chk($sformatf("rnd_res%0d", got), {out_sum, out_co, out_ovf}, r);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(rv.a, rv.b, rv.ci, rv.sub, rv.sat));
        sent++;
      end
    end
    chk("rnd_count", got, 300);

    // Back-to-back stream: must sustain one op per cycle
    q.delete();
    sent = 0; got = 0; stalls = 0;
    for (cyc = 0; cyc < 1000 && got < 200; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      rv.a = $urandom; rv.b = $urandom;
      rv.ci = $urandom_range(0, 1); rv.sub = $urandom_range(0, 1); rv.sat = $urandom_range(0, 1);
      drive(rv, sent < 200);
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("b2b_unexpected_output", 1, 0);
        else begin
          r = q.pop_front();
          chk($sformatf("b2b_res%0d", got), {out_sum, out_co, out_ovf}, r);
        end
        got++;
      end
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) begin
        q.push_back(model(rv.a, rv.b, rv.ci, rv.sub, rv.sat));
        sent++;
      end
    end
    chk("b2b_count", got, 200);
    chk("b2b_stalls", stalls, 0);
    chk("b2b_cycles", cyc, 200 + P);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_pipe_cs.md
Name: adder_pipe_cs

Overview:
- Parametrised, pipelined carry-select adder/subtractor.
- Successor to the fixed 32-bit combinational carry-select adder; generalised in width, block size and pipeline depth.
- Adds a subtract mode, signed-overflow reporting and a valid/ready stream interface.
- Sits in the datapath ALU as the add/sub unit. Full throughput is one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of BLK.
- BLK, 4, carry-select block width in bits.
- PIPE, 2, number of register stages (latency), 1..NBLK. NBLK = WIDTH/BLK must be a multiple of PIPE.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  unit can accept an operation this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_ci  in  1  carry-in (add) / borrow-in (sub)
- in_sub  in  1  1 = A - B, 0 = A + B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  result
- out_co  out  1  carry-out of MSB (in sub mode, 1 = no borrow)
- out_ovf  out  1  signed overflow

Behaviour:
- Reset: every stage valid bit clears to 0, so out_valid=0. out_sum, out_co, out_ovf and all stage data registers clear to 0. in_ready=1 once rst_n is high.
- Arithmetic:
  - b_eff = in_sub ? ~in_b : in_b
  - c0 = in_ci ^ in_sub
  - sub=0,ci=0: A+B; sub=0,ci=1: A+B+1; sub=1,ci=0: A-B; sub=1,ci=1: A-B-1.
  - Result is computed modulo 2^WIDTH.
  - out_ovf = carry into MSB XOR carry out of MSB.
- Carry-select structure:
  - Each BLK slice computes its sum for carry-in 0 and for carry-in 1 in parallel.
  - The incoming block carry selects the sum and the carry-out.
  - Block 0 uses c0 directly.
- Pipelining:
  - Stage s (0..PIPE-1) resolves blocks s*NBLK/PIPE .. (s+1)*NBLK/PIPE-1, using the carry registered by stage s-1.
  - Each stage registers: valid, resolved sum bits, running carry, carry into MSB (last stage only), remaining operand bits, sub flag.
  - The last stage register drives the outputs directly.
- Latency: an operation accepted at edge k appears with out_valid=1 after edge k+PIPE-1 (PIPE register stages).
- Handshake:
  - Transfer occurs on a cycle where valid and ready are both 1.
  - Stage s loads when it is empty or when stage s+1 loads (last stage: when out_ready=1).
  - in_ready = stage-0 load condition. It is combinational from out_ready through the stage valids, with no skid buffer.
  - While out_valid=1 and out_ready=0, out_sum/out_co/out_ovf hold stable.
  - Ordering is strictly FIFO.
- Boundary conditions:
  - Simultaneous output pop and input push with all stages full: the pipeline shifts and both transfers occur.
  - in_valid=0: bubbles propagate; the data registers of empty stages may hold old values but valid=0.
  - rst_n low mid-operation: all in-flight operations are discarded immediately (asynchronous). No output appears for them after release.
  - Input data is ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN.
- With the macro: an extra input port in_sat (1 bit) is captured with the operation.
  - When in_sat=1 and ovf=1, out_sum saturates to the signed limit. A result MSB of 1 gives the signed max (0x7FF..F); a result MSB of 0 gives the signed min (0x800..0).
  - out_ovf still reports 1. out_co is unchanged.
  - Saturation is applied in the last stage before its register; latency is unchanged.
- Without the macro: the in_sat port is absent and results always wrap.

Decomposition:
- Package adder_pipe_pkg:
  - derived constants NBLK and BLK_PER_STAGE
  - elaboration checks (WIDTH % BLK == 0, NBLK % PIPE == 0)
  - signed max/min constant functions for the saturation limits
- Sub-module cs_block: one BLK-bit carry-select slice.
  - Inputs: a, b, cin.
  - Outputs: sum, cout.
  - Contains two ripple sums (cin 0 and cin 1) plus the select mux.
  - Instantiated NBLK times across the stages.

Test Plan (WIDTH=32, BLK=4, PIPE=2 unless noted):
- 0xFFFFFFFF + 0x00000001, ci=0, sub=0, out_ready=1 -> after 2 edges: sum=0x00000000, co=1, ovf=0.
- 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, co=0, ovf=1. With ADDER_PIPE_SAT_EN and in_sat=1 -> sum=0x7FFFFFFF, ovf=1.
- sub=1: 5 - 7, ci=0 -> sum=0xFFFFFFFE, co=0, ovf=0. Same operands with ci=1 -> sum=0xFFFFFFFD.
- Backpressure: out_ready=0, in_valid=1 stream of 4 ops -> exactly 2 accepted, then in_ready=0 and outputs held stable. Raise out_ready -> remaining results arrive in order at 1/cycle.
- Reset: pull rst_n low with 2 ops in flight -> out_valid=0 immediately. After release, no stale result; the next op completes normally.
- Random back-to-back stream of 10k ops against a reference model, run for PIPE=1, PIPE=8 and WIDTH=16/BLK=2 -> zero mismatches, throughput 1 op/cycle.
